reg_file_param: RTL
===================

Name: reg_file_param

Overview:
Parametrised successor to the 8x8 register file. It has a configurable data width and depth, N independent read ports and one write port. Reads are registered with a valid strobe, and same-cycle writes are bypassed to the read ports. A self-clearing sequencer zeroes every entry after reset or on request. An optional hardwired-zero register is available. It sits between the decode stage (addresses) and the ALU/datapath (operands, writeback).

Parameters:
W, 8, data width in bits
DEPTH, 8, number of entries; must be >= 2, need not be a power of two
N_RD, 2, number of read ports; must be >= 1
ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes
AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
clear_req  in  1  pulse; restarts the clear sequence
wr_en  in  1  write strobe
wr_addr  in  AW  write address
wr_data  in  W  write data
rd_en  in  1  read strobe, shared by all ports
rd_addr  in  N_RD*AW  packed read addresses; port i uses slice [i*AW +: AW]
rd_data  out  N_RD*W  packed registered read data
rd_valid  out  1  rd_data updated this cycle
init_busy  out  1  clear sequence in progress

Behaviour:
- Reset (asynchronous, active-high). While reset is high:
  - FSM = CLEAR, clr_idx = 0, init_busy = 1.
  - rd_data = 0, rd_valid = 0.
  - The storage array has no reset flops; it is zeroed by the sequencer.
- FSM states CLEAR and RUN.
  - CLEAR: each cycle writes 0 to entry clr_idx, then clr_idx++. After the write at clr_idx == DEPTH-1, the next state is RUN with init_busy = 0. The sequence takes exactly DEPTH cycles after reset deassertion.
  - RUN: clear_req = 1 sends the FSM to CLEAR with clr_idx = 0 next cycle.
  - clear_req in CLEAR restarts clr_idx at 0.
- During CLEAR:
  - wr_en is ignored; the write is dropped and not queued.
  - rd_en is ignored: rd_valid = 0 and rd_data holds its value.
- Writes (RUN only): on the rising edge with wr_en = 1 and wr_addr < DEPTH, mem[wr_addr] <= wr_data.
  - wr_addr >= DEPTH: the write is dropped.
  - ZERO_REG = 1 and wr_addr == 0: the write is dropped.
- Reads (RUN only): 1-cycle latency. rd_en = 1 at edge t produces, at t+1, rd_data slice i = value(rd_addr slice i) and rd_valid = 1.
  - rd_en = 0: rd_valid = 0 and rd_data holds its last value.
  - Ports are fully independent; any ports may share an address.
- Bypass: if wr_en and rd_en are both active in the same cycle and a read address equals wr_addr (write not dropped), that port returns wr_data, not the stale entry.
- Reads of an address >= DEPTH return 0.
- ZERO_REG = 1: reads of address 0 return 0.
- clear_req takes effect one edge later, so a read issued in the same cycle as clear_req in RUN still completes normally.
- Reset asserted mid-operation: every output returns to its reset value immediately (asynchronous), and the clear sequence restarts from 0.
- No tri-state outputs anywhere; all outputs are driven at all times.

Decomposition:
- Package reg_file_pkg holds the state enum typedef rf_state_e {RF_CLEAR, RF_RUN} and the localparam default values for W, DEPTH and N_RD.
- Sub-module rf_read_port: one instance per read port via generate. It takes the address, array contents and bypass inputs and produces the registered W-bit data. It contains the out-of-range, ZERO_REG and bypass muxing.
- Top level holds the FSM, the clear counter, the array and the write logic.

Test Plan:
- Reset release: hold reset 3 cycles, then release. init_busy = 1 for exactly 8 cycles, then 0. Reading all 8 entries then returns 0x00, and rd_valid pulses one cycle after each rd_en.
- Write/read latency: write 0xA5 to entry 3, next cycle rd_en with port0 = 3 and port1 = 3. One cycle later both ports read 0xA5 with rd_valid = 1. With rd_en low the next cycle, rd_valid = 0 and the data holds 0xA5.
- Bypass: same cycle, wr_en = 1 to addr 5 with 0x3C, and rd_en = 1 with port0 = 5, port1 = 2 (2 holds 0x11). Next cycle port0 = 0x3C, port1 = 0x11.
- Writes during clear: pulse clear_req, then drive wr_en to addr 1 with 0xFF during CLEAR. After init_busy falls, reading addr 1 returns 0x00.
- ZERO_REG = 1 and out-of-range (DEPTH = 6): write 0x77 to addr 0 and 0x55 to addr 7. Reads of 0 and 7 return 0x00; all other entries are unchanged.
- Mid-operation reset: assert reset during a read. rd_valid and rd_data go to 0 in the same cycle without waiting for an edge, and after release init_busy is high for DEPTH cycles.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the parametrised register file.
package reg_file_pkg;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state_e;

    localparam int RF_W_DEF     = 8;
    localparam int RF_DEPTH_DEF = 8;
    localparam int RF_N_RD_DEF  = 2;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: selects stored word, same-cycle write data, or zero.
module rf_read_port #(
    parameter int W        = 8,
    parameter int DEPTH    = 8,
    parameter bit ZERO_REG = 1'b0,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  mem_words [DEPTH],
    input  logic          byp_en,
    input  logic [AW-1:0] byp_addr,
    input  logic [W-1:0]  byp_data,
    output logic [W-1:0]  data
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [W-1:0] data_reg;
    logic [W-1:0] data_next;
    logic         in_range;

    assign in_range = {1'b0, addr} < DEPTH_W;

    // byp_en is only raised for writes that actually land, so it never aliases
    // an out-of-range or hardwired-zero address.
    always_comb begin
        data_next = '0;
        if (!in_range) begin
            data_next = '0;
        end else if (ZERO_REG && addr == '0) begin
            data_next = '0;
        end else if (byp_en && byp_addr == addr) begin
            data_next = byp_data;
        end else begin
            data_next = mem_words[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
        end else if (en) begin
            data_reg <= data_next;
        end
    end

    assign data = data_reg;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: N read ports, one write port, write-to-read
// bypass and a self-clearing sequencer that zeroes storage after reset.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int   W        = RF_W_DEF,
    parameter int   DEPTH    = RF_DEPTH_DEF,
    parameter int   N_RD     = RF_N_RD_DEF,
    parameter bit   ZERO_REG = 1'b0,
    localparam int  AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_req,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [W-1:0]       wr_data,
    input  logic               rd_en,
    input  logic [N_RD*AW-1:0] rd_addr,
    output logic [N_RD*W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               init_busy
);

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    rf_state_e     state_reg, state_next;
    logic [AW-1:0] clr_idx_reg, clr_idx_next;
    logic          rd_valid_reg;
    logic [W-1:0]  mem [DEPTH];

    logic run;
    logic wr_ok;
    logic rd_ok;

    assign run   = (state_reg == RF_RUN);
    assign wr_ok = run && wr_en && ({1'b0, wr_addr} < DEPTH_W)
                   && !(ZERO_REG && wr_addr == '0);
    assign rd_ok = run && rd_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= RF_CLEAR;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        case (state_reg)
            RF_CLEAR: begin
                if (clear_req) begin
                    clr_idx_next = '0;
                end else if (clr_idx_reg == LAST_IDX) begin
                    state_next   = RF_RUN;
                    clr_idx_next = '0;
                end else begin
                    clr_idx_next = clr_idx_reg + AW'(1);
                end
            end
            RF_RUN: begin
                if (clear_req) begin
                    state_next   = RF_CLEAR;
                    clr_idx_next = '0;
                end
            end
            default: begin
                state_next   = RF_CLEAR;
                clr_idx_next = '0;
            end
        endcase
    end

    // Storage has no reset; the sequencer owns the write port while clearing.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_idx_reg] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_ok;
        end
    end

    generate
        for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
            rf_read_port #(
                .W        (W),
                .DEPTH    (DEPTH),
                .ZERO_REG (ZERO_REG),
                .AW       (AW)
            ) u_port (
                .clk       (clk),
                .rst       (reset),
                .en        (rd_ok),
                .addr      (rd_addr[gi*AW +: AW]),
                .mem_words (mem),
                .byp_en    (wr_ok),
                .byp_addr  (wr_addr),
                .byp_data  (wr_data),
                .data      (rd_data[gi*W +: W])
            );
        end
    endgenerate

    assign rd_valid  = rd_valid_reg;
    assign init_busy = (state_reg == RF_CLEAR);

endmodule
